// File: rtl/cache_mem_arb_pkg.sv
//==============================================================================
// Module      : cache_arb_pkg
// Description : Shared types and default widths for the cache memory-port
//               arbiter (state encoding, requester count, bus widths).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    localparam int c_def_n_req       = 4;
    localparam int c_def_addr_wdt    = 32;
    localparam int c_def_data_wdt    = 64;
    localparam int c_def_timeout_cyc = 1024;

endpackage

`default_nettype wire

// File: rtl/cache_mem_arb_if.sv
//==============================================================================
// Module      : cache_mem_arb_if
// Description : Bundle of cache-side miss signals and DRAM-side port signals
//               shared by the arbiter and its surroundings.
//               master : caches + memory model (drive requests / read data)
//               slave  : the arbiter (drives responses / memory requests)
// Ports       : req_en, req_addr, rsp_valid, rsp_data, mem_req_en,
//               mem_req_addr, mem_read_valid, mem_read_data, busy,
//               err_timeout
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface cache_mem_arb_if
    import cache_arb_pkg::*;
#(
    parameter int N_REQ    = c_def_n_req,
    parameter int ADDR_WDT = c_def_addr_wdt,
    parameter int DATA_WDT = c_def_data_wdt
);

    logic [N_REQ-1:0]          req_en;
    logic [N_REQ*ADDR_WDT-1:0] req_addr;
    logic [N_REQ-1:0]          rsp_valid;
    logic [DATA_WDT-1:0]       rsp_data;
    logic                      mem_req_en;
    logic [ADDR_WDT-1:0]       mem_req_addr;
    logic                      mem_read_valid;
    logic [DATA_WDT-1:0]       mem_read_data;
    logic                      busy;
    logic                      err_timeout;

    modport master (
        output req_en, req_addr, mem_read_valid, mem_read_data,
        input  rsp_valid, rsp_data, mem_req_en, mem_req_addr, busy, err_timeout
    );

    modport slave (
        input  req_en, req_addr, mem_read_valid, mem_read_data,
        output rsp_valid, rsp_data, mem_req_en, mem_req_addr, busy, err_timeout
    );

endinterface

`default_nettype wire

// File: rtl/cache_mem_arb_rr_pick.sv
//==============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Scans candidates starting
//               one past i_ptr (wrapping) and returns the first one set.
// Ports       : i_cand   - candidate vector
//               i_ptr    - index of the last winner
//               o_onehot - one-hot grant
//               o_bin    - binary grant
//               o_any    - at least one candidate present
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_pick #(
    parameter int N_REQ = 4
) (
    input  wire logic [N_REQ-1:0]         i_cand,
    input  wire logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic      [N_REQ-1:0]         o_onehot,
    output logic      [$clog2(N_REQ)-1:0] o_bin,
    output logic                          o_any
);

    localparam int IDX_WDT = $clog2(N_REQ);

    int w_idx;

    always_comb begin
        o_onehot = '0;
        o_bin    = '0;
        o_any    = 1'b0;
        w_idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = (int'(i_ptr) + k) % N_REQ;
            if (!o_any && i_cand[w_idx]) begin
                o_any           = 1'b1;
                o_bin           = IDX_WDT'(w_idx);
                o_onehot[w_idx] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cache_mem_arb.sv
//==============================================================================
// Module      : cache_mem_arb
// Description : Round-robin arbiter sharing one DRAM port among N_REQ L1
//               caches. Latches single-cycle miss requests, issues one memory
//               request at a time and routes the returned word back to the
//               owner as a one-hot pulse. One transaction in flight at most.
// Ports       : clk, rst (sync, active-high), bus (cache_mem_arb_if.slave)
// Macros      : CACHE_ARB_TIMEOUT_EN - enables the WAIT watchdog; on expiry
//               the owner gets a response with zero data and err_timeout
//               pulses. Undefined: WAIT is unbounded, err_timeout tied low.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cache_mem_arb
    import cache_arb_pkg::*;
#(
    parameter int N_REQ       = c_def_n_req,
    parameter int ADDR_WDT    = c_def_addr_wdt,
    parameter int DATA_WDT    = c_def_data_wdt,
    parameter int TIMEOUT_CYC = c_def_timeout_cyc
) (
    input wire logic       clk,
    input wire logic       rst,
    cache_mem_arb_if.slave bus
);

    localparam int               IDX_WDT = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] c_one   = N_REQ'(1);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("cache_mem_arb: N_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    arb_state_e          r_state;
    logic [N_REQ-1:0]    r_pend;
    logic [ADDR_WDT-1:0] r_addr [N_REQ];
    logic [IDX_WDT-1:0]  r_ptr;
    logic [IDX_WDT-1:0]  r_grant;
    logic                r_mem_req_en;
    logic [ADDR_WDT-1:0] r_mem_req_addr;   // doubles as the granted address
    logic [N_REQ-1:0]    r_rsp_valid;
    logic [DATA_WDT-1:0] r_rsp_data;

    logic [N_REQ-1:0]    w_cand;
    logic [N_REQ-1:0]    w_gnt_oh;
    logic [IDX_WDT-1:0]  w_gnt_bin;
    logic                w_any;
    logic [ADDR_WDT-1:0] w_gnt_addr;
    logic                w_expire;
    logic                w_done;
    logic [N_REQ-1:0]    w_grant_oh;
    logic [N_REQ-1:0]    w_done_oh;

    // A request arriving in IDLE competes in the same cycle it is latched.
    assign w_cand = r_pend | bus.req_en;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .i_cand   (w_cand),
        .i_ptr    (r_ptr),
        .o_onehot (w_gnt_oh),
        .o_bin    (w_gnt_bin),
        .o_any    (w_any)
    );

    // A pending requester cannot have its address replaced outside
    // completion, so a set pend bit always means the stored address wins.
    always_comb begin
        w_gnt_addr = bus.req_addr[int'(w_gnt_bin)*ADDR_WDT +: ADDR_WDT];
        if (r_pend[w_gnt_bin]) begin
            w_gnt_addr = r_addr[w_gnt_bin];
        end
    end

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int CNT_WDT = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_WDT-1:0] r_cnt;
    logic               r_err_timeout;

    // Memory data in the expiry cycle is a normal completion.
    assign w_expire = (r_state == WAIT) && !bus.mem_read_valid &&
                      (r_cnt == CNT_WDT'(TIMEOUT_CYC - 1));
    assign bus.err_timeout = r_err_timeout;
`else
    assign w_expire        = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    assign w_done     = (r_state == WAIT) && (bus.mem_read_valid || w_expire);
    assign w_grant_oh = c_one << r_grant;
    assign w_done_oh  = w_done ? w_grant_oh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_pend         <= '0;
            r_ptr          <= IDX_WDT'(N_REQ - 1);
            r_grant        <= '0;
            r_mem_req_en   <= 1'b0;
            r_mem_req_addr <= '0;
            r_rsp_valid    <= '0;
            r_rsp_data     <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_addr[i] <= '0;
            end
`ifdef CACHE_ARB_TIMEOUT_EN
            r_cnt          <= '0;
            r_err_timeout  <= 1'b0;
`endif
        end else begin
            r_mem_req_en <= 1'b0;
            r_rsp_valid  <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
            r_err_timeout <= 1'b0;
`endif

            // Completion of requester i lets a same-cycle re-request in;
            // otherwise a duplicate while pending is dropped.
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_en[i] && (!r_pend[i] || w_done_oh[i])) begin
                    r_pend[i] <= 1'b1;
                    r_addr[i] <= bus.req_addr[i*ADDR_WDT +: ADDR_WDT];
                end else if (w_done_oh[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant        <= w_gnt_bin;
                        r_mem_req_addr <= w_gnt_addr;
                        r_mem_req_en   <= 1'b1;
                        r_state        <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef CACHE_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (bus.mem_read_valid) begin
                        r_rsp_valid <= w_grant_oh;
                        r_rsp_data  <= bus.mem_read_data;
                        r_ptr       <= r_grant;
                        r_state     <= IDLE;
                    end
`ifdef CACHE_ARB_TIMEOUT_EN
                    else if (w_expire) begin
                        r_rsp_valid   <= w_grant_oh;
                        r_rsp_data    <= '0;
                        r_err_timeout <= 1'b1;
                        r_ptr         <= r_grant;
                        r_state       <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req_en   = r_mem_req_en;
    assign bus.mem_req_addr = r_mem_req_addr;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.busy         = (r_state != IDLE) || (|r_pend);

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arb.sv
//==============================================================================
// Module      : tb_cache_mem_arb
// Description : Directed self-checking bench for cache_mem_arb (4 requesters,
//               32-bit address, 64-bit data, 16-cycle watchdog when
//               CACHE_ARB_TIMEOUT_EN is defined).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cache_mem_arb;

    localparam int N_REQ    = 4;
    localparam int ADDR_WDT = 32;
    localparam int DATA_WDT = 64;

    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    cache_mem_arb_if #(
        .N_REQ    (N_REQ),
        .ADDR_WDT (ADDR_WDT),
        .DATA_WDT (DATA_WDT)
    ) bus ();

    cache_mem_arb #(
        .N_REQ       (N_REQ),
        .ADDR_WDT    (ADDR_WDT),
        .DATA_WDT    (DATA_WDT),
        .TIMEOUT_CYC (16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [3:0] mask, input logic [31:0] a0,
                             input logic [31:0] a1, input logic [31:0] a2,
                             input logic [31:0] a3);
        bus.req_en   = mask;
        bus.req_addr = {a3, a2, a1, a0};
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.req_en         = '0;
        bus.mem_read_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for the memory request, checks its address, answers it
    // one cycle later and checks the routed response.
    task automatic serve(input string tag, input logic [31:0] exp_addr,
                         input logic [63:0] data, input logic [3:0] exp_rsp);
        int k = 0;
        while (!bus.mem_req_en && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_req"}, 64'(bus.mem_req_en), 64'd1);
        chk({tag, "_addr"}, 64'(bus.mem_req_addr), 64'(exp_addr));
        tick();
        bus.mem_read_valid = 1'b1;
        bus.mem_read_data  = data;
        tick();
        bus.mem_read_valid = 1'b0;
        chk({tag, "_rsp"}, 64'(bus.rsp_valid), 64'(exp_rsp));
        chk({tag, "_data"}, bus.rsp_data, data);
    endtask

    initial begin
        rst                = 1'b1;
        bus.req_en         = '0;
        bus.req_addr       = '0;
        bus.mem_read_valid = 1'b0;
        bus.mem_read_data  = '0;

        // Reset values
        tick();
        tick();
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_data", bus.rsp_data, 64'd0);
        chk("rst_mem_req_en", 64'(bus.mem_req_en), 64'd0);
        chk("rst_mem_req_addr", 64'(bus.mem_req_addr), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_err", 64'(bus.err_timeout), 64'd0);
        rst = 1'b0;
        tick();

        // Single request: mem_req_en exactly one cycle after req_en
        drive_req(4'b0001, 32'h100, 32'h0, 32'h0, 32'h0);
        tick();
        bus.req_en = '0;
        chk("single_lat_req", 64'(bus.mem_req_en), 64'd1);
        chk("single_busy", 64'(bus.busy), 64'd1);
        serve("single", 32'h100, 64'hDEAD, 4'b0001);
        chk("single_idle_busy", 64'(bus.busy), 64'd0);
        tick();
        chk("single_rsp_pulse", 64'(bus.rsp_valid), 64'd0);
        chk("single_data_hold", bus.rsp_data, 64'hDEAD);

        // Simultaneous requests after reset: 0,1,2,3 order
        do_reset();
        drive_req(4'b1111, 32'h0, 32'h40, 32'h80, 32'hC0);
        tick();
        bus.req_en = '0;
        serve("sim0", 32'h0,  64'h10, 4'b0001);
        serve("sim1", 32'h40, 64'h11, 4'b0010);
        serve("sim2", 32'h80, 64'h12, 4'b0100);
        serve("sim3", 32'hC0, 64'h13, 4'b1000);
        chk("sim_busy_end", 64'(bus.busy), 64'd0);

        // Fairness: after requester 2, 3 beats 1
        do_reset();
        drive_req(4'b0100, 32'h0, 32'h0, 32'h200, 32'h0);
        tick();
        bus.req_en = '0;
        serve("fair2", 32'h200, 64'h22, 4'b0100);
        drive_req(4'b1010, 32'h0, 32'h110, 32'h0, 32'h310);
        tick();
        bus.req_en = '0;
        serve("fair3", 32'h310, 64'h33, 4'b1000);
        serve("fair1", 32'h110, 64'h11, 4'b0010);

        // Re-request at completion; duplicate during WAIT is ignored
        drive_req(4'b0001, 32'h500, 32'h0, 32'h0, 32'h0);
        tick();
        bus.req_en = '0;
        chk("rereq_first_req", 64'(bus.mem_req_en), 64'd1);
        chk("rereq_first_addr", 64'(bus.mem_req_addr), 64'h500);
        tick();
        drive_req(4'b0001, 32'h5FF, 32'h0, 32'h0, 32'h0);
        tick();
        bus.req_en = '0;
        tick();
        chk("rereq_wait_noreq", 64'(bus.mem_req_en), 64'd0);
        drive_req(4'b0001, 32'h600, 32'h0, 32'h0, 32'h0);
        bus.mem_read_valid = 1'b1;
        bus.mem_read_data  = 64'h1111;
        tick();
        bus.req_en         = '0;
        bus.mem_read_valid = 1'b0;
        chk("rereq_rsp", 64'(bus.rsp_valid), 64'b0001);
        chk("rereq_rsp_data", bus.rsp_data, 64'h1111);
        chk("rereq_m1_noreq", 64'(bus.mem_req_en), 64'd0);
        chk("rereq_m1_busy", 64'(bus.busy), 64'd1);
        tick();
        chk("rereq_m2_req", 64'(bus.mem_req_en), 64'd1);
        serve("rereq2", 32'h600, 64'h2222, 4'b0001);
        chk("rereq_busy_end", 64'(bus.busy), 64'd0);

        // Reset while in WAIT, then late memory data
        drive_req(4'b0010, 32'h0, 32'h700, 32'h0, 32'h0);
        tick();
        bus.req_en = '0;
        tick();
        rst = 1'b1;
        tick();
        rst                = 1'b0;
        bus.mem_read_valid = 1'b1;
        bus.mem_read_data  = 64'h3333;
        tick();
        bus.mem_read_valid = 1'b0;
        chk("rstwait_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("rstwait_busy", 64'(bus.busy), 64'd0);
        chk("rstwait_data", bus.rsp_data, 64'd0);
        tick();
        chk("rstwait_noreq", 64'(bus.mem_req_en), 64'd0);
        chk("rstwait_rsp2", 64'(bus.rsp_valid), 64'd0);

`ifdef CACHE_ARB_TIMEOUT_EN
        // Watchdog: pulse 16 cycles after entering WAIT with zero data
        drive_req(4'b0001, 32'hA00, 32'h0, 32'h0, 32'h0);
        tick();
        bus.req_en = '0;
        serve("pre_to", 32'hA00, 64'hABCD, 4'b0001);
        drive_req(4'b1000, 32'h0, 32'h0, 32'h0, 32'h900);
        tick();
        bus.req_en = '0;
        chk("to_req", 64'(bus.mem_req_en), 64'd1);
        chk("to_addr", 64'(bus.mem_req_addr), 64'h900);
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("to_early_err", 64'(bus.err_timeout), 64'd0);
        chk("to_early_rsp", 64'(bus.rsp_valid), 64'd0);
        tick();
        chk("to_err", 64'(bus.err_timeout), 64'd1);
        chk("to_rsp", 64'(bus.rsp_valid), 64'b1000);
        chk("to_data", bus.rsp_data, 64'd0);
        chk("to_busy", 64'(bus.busy), 64'd0);
        tick();
        chk("to_err_pulse", 64'(bus.err_timeout), 64'd0);
`else
        chk("no_to_err", 64'(bus.err_timeout), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
